// File: rtl/ppu_rx.sv
// rtl/ppu_rx.sv - post-processing receiver: max-abs scan, shift search, requantized output writes
module ppu_rx #(
   parameter int VL        = 8,
   parameter int ACC_W     = 24,
   parameter int OUT_W     = 8,
   parameter int ADDR_W    = 16,
   parameter int TILES     = 16,
   parameter int VSQ_SHIFT = 6
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic [1:0]            i_mode,
   input  logic [ACC_W*VL-1:0]   i_acc_data,
   output logic                  o_wr_en,
   output logic [ADDR_W-1:0]     o_wr_addr,
   output logic [OUT_W*VL-1:0]   o_wr_data,
   output logic [4:0]            o_shift,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_err
);
   localparam int DW     = ACC_W * VL;
   localparam int BEAT_W = (VL > 1) ? $clog2(VL) : 1;
   localparam int TILE_W = $clog2(TILES) + 1;
   localparam int CNT_W  = $clog2(VL + 1);

   localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(VL - 1);
   localparam logic [TILE_W-1:0] LAST_TILE   = TILE_W'(TILES - 1);
   localparam logic [ACC_W-1:0]  ACC_POS_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0]  ACC_NEG_MIN = {1'b1, {(ACC_W-1){1'b0}}};
   localparam logic [1:0]        MODE_INT4   = 2'd1;
   localparam logic [1:0]        MODE_VSQ    = 2'd2;

   typedef enum logic [1:0] {IDLE, RECV, SHIFT, DONE} state_t;
   state_t state_q, state_d;

   // matrix control
   logic [1:0]        mode_q;
   logic              pass_q;        // 0 = max pass, 1 = out pass
   logic [TILE_W-1:0] tile_cnt_q;
   logic [BEAT_W-1:0] proc_beat_q;
   logic [ACC_W-1:0]  max_abs_q;
   logic [4:0]        s_work_q;

   // input framing: tracks beats of the most recently accepted start
   logic              cap_active_q;
   logic [BEAT_W-1:0] cap_beat_q;
   logic              pend_q;        // one tile already accepted during SHIFT

   // skid FIFO holding beats that arrive while the shift is still being searched
   logic [DW-1:0]     fifo_mem [VL];
   logic [BEAT_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  fifo_cnt_q;

   logic                     cap_at_last, frame_open, start_acc, start_err;
   logic                     fifo_empty, push, pop, proc_vld, proc_last, shift_more;
   logic [DW-1:0]            proc_data;
   logic [ACC_W-1:0]         qmax_u, beat_max, lane, lane_abs;
   logic signed [ACC_W:0]    qmax_s, rnd, sum, q;
   logic [OUT_W*VL-1:0]      q_data;
   logic [ADDR_W-1:0]        wr_addr;

   // framing, start acceptance and beat routing (live beat or FIFO head)
   always_comb begin
      qmax_u      = (mode_q == MODE_INT4 || mode_q == MODE_VSQ) ? ACC_W'(7) : ACC_W'(127);
      qmax_s      = signed'({1'b0, qmax_u});
      cap_at_last = cap_active_q && (cap_beat_q == LAST_BEAT);
      frame_open  = !cap_active_q || cap_at_last;
      start_err   = i_start && (state_q == RECV || state_q == SHIFT) && !frame_open;
      start_acc   = i_start && ((state_q == IDLE) ||
                                (state_q == RECV && frame_open) ||
                                (state_q == SHIFT && frame_open && !pend_q));
      fifo_empty  = (fifo_cnt_q == '0);
      proc_vld    = (state_q == RECV) && (!fifo_empty || cap_active_q);
      proc_data   = fifo_empty ? i_acc_data : fifo_mem[rd_ptr_q];
      pop         = (state_q == RECV) && !fifo_empty;
      push        = cap_active_q && ((state_q == SHIFT) || (state_q == RECV && !fifo_empty));
      proc_last   = proc_vld && (proc_beat_q == LAST_BEAT) && (tile_cnt_q == LAST_TILE);
      shift_more  = (max_abs_q >> s_work_q) > qmax_u;
      wr_addr     = ADDR_W'(tile_cnt_q) * ADDR_W'(VL) + ADDR_W'(proc_beat_q);
   end

   // per-lane magnitude for the max pass and round-half-up saturating requantization for the out pass
   always_comb begin
      beat_max = '0;
      q_data   = '0;
      lane     = '0;
      lane_abs = '0;
      sum      = '0;
      q        = '0;
      rnd      = (o_shift == 5'd0) ? '0 : signed'((ACC_W+1)'(1) << (o_shift - 5'd1));
      for (int g = 0; g < VL; g++) begin
         lane = proc_data[g*ACC_W +: ACC_W];
         if (lane == ACC_NEG_MIN)
            lane_abs = ACC_POS_MAX;
         else if (lane[ACC_W-1])
            lane_abs = -lane;
         else
            lane_abs = lane;
         if (lane_abs > beat_max)
            beat_max = lane_abs;
         sum = signed'({lane[ACC_W-1], lane}) + rnd;
         q   = sum >>> o_shift;
         if (q > qmax_s)
            q = qmax_s;
         else if (q < -qmax_s)
            q = -qmax_s;
         q_data[g*OUT_W +: OUT_W] = q[OUT_W-1:0];
      end
   end

   // state register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_acc) state_d = RECV;
         RECV:    if (proc_last) state_d = pass_q ? DONE : SHIFT;
         SHIFT:   if (!shift_more) state_d = RECV;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // state-decoded outputs
   always_comb begin
      o_busy = (state_q != IDLE);
   end

   // beat framing, pending-start flag and sticky error
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cap_active_q <= 1'b0;
         cap_beat_q   <= '0;
         pend_q       <= 1'b0;
         o_err        <= 1'b0;
      end else begin
         if (start_acc) begin
            cap_active_q <= 1'b1;
            cap_beat_q   <= '0;
         end else if (cap_active_q) begin
            if (cap_at_last) cap_active_q <= 1'b0;
            else             cap_beat_q   <= cap_beat_q + 1'b1;
         end
         if (start_acc && state_d == SHIFT) pend_q <= 1'b1;
         else if (state_d != SHIFT)         pend_q <= 1'b0;
         if (start_err) o_err <= 1'b1;
      end
   end

   // matrix sequencing: mode latch, tile/beat counters, max tracking and shift search
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         mode_q      <= '0;
         pass_q      <= 1'b0;
         tile_cnt_q  <= '0;
         proc_beat_q <= '0;
         max_abs_q   <= '0;
         s_work_q    <= '0;
         o_shift     <= '0;
      end else begin
         case (state_q)
            IDLE: if (start_acc) begin
               mode_q      <= i_mode;
               tile_cnt_q  <= '0;
               proc_beat_q <= '0;
               max_abs_q   <= '0;
               s_work_q    <= '0;
               if (i_mode == MODE_VSQ) begin
                  pass_q  <= 1'b1;
                  o_shift <= 5'(VSQ_SHIFT);
               end else begin
                  pass_q  <= 1'b0;
               end
            end
            RECV: if (proc_vld) begin
               if (!pass_q && beat_max > max_abs_q) max_abs_q <= beat_max;
               if (proc_beat_q == LAST_BEAT) begin
                  proc_beat_q <= '0;
                  tile_cnt_q  <= (tile_cnt_q == LAST_TILE) ? '0 : tile_cnt_q + 1'b1;
               end else begin
                  proc_beat_q <= proc_beat_q + 1'b1;
               end
               if (proc_last) s_work_q <= '0;
            end
            SHIFT: begin
               if (shift_more) begin
                  s_work_q <= s_work_q + 5'd1;
               end else begin
                  o_shift     <= s_work_q;
                  pass_q      <= 1'b1;
                  tile_cnt_q  <= '0;
                  proc_beat_q <= '0;
               end
            end
            DONE: max_abs_q <= '0;
            default: ;
         endcase
      end
   end

   // skid FIFO pointers and occupancy
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= '0;
      end else begin
         if (push) wr_ptr_q <= (wr_ptr_q == LAST_BEAT) ? '0 : wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= (rd_ptr_q == LAST_BEAT) ? '0 : rd_ptr_q + 1'b1;
         if (push && !pop)      fifo_cnt_q <= fifo_cnt_q + 1'b1;
         else if (!push && pop) fifo_cnt_q <= fifo_cnt_q - 1'b1;
      end
   end

   // skid FIFO storage
   always_ff @(posedge i_clk) begin
      if (push) fifo_mem[wr_ptr_q] <= i_acc_data;
   end

   // registered write port and done pulse
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_wr_en   <= 1'b0;
         o_wr_addr <= '0;
         o_wr_data <= '0;
         o_done    <= 1'b0;
      end else begin
         o_wr_en <= proc_vld && pass_q;
         if (proc_vld && pass_q) begin
            o_wr_addr <= wr_addr;
            o_wr_data <= q_data;
         end
         o_done <= (state_q == DONE);
      end
   end
endmodule

// File: tb/tb_ppu_rx.sv
// tb/tb_ppu_rx.sv - scoreboard bench for ppu_rx
module tb_ppu_rx;
   localparam int VL = 8, ACC_W = 24, OUT_W = 8, ADDR_W = 16, TILES = 4, VSQ_SHIFT = 6;
   localparam int DW = ACC_W * VL;
   localparam int OW = OUT_W * VL;

   logic              clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [1:0]        mode = 2'd0;
   logic [DW-1:0]     acc = '0;
   logic              o_wr_en, o_busy, o_done, o_err;
   logic [ADDR_W-1:0] o_wr_addr;
   logic [OW-1:0]     o_wr_data;
   logic [4:0]        o_shift;

   ppu_rx #(.VL(VL), .ACC_W(ACC_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W), .TILES(TILES),
            .VSQ_SHIFT(VSQ_SHIFT)) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_mode(mode), .i_acc_data(acc),
      .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_shift(o_shift),
      .o_busy(o_busy), .o_done(o_done), .o_err(o_err));

   always #5 clk = ~clk;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [OW-1:0]     data;
      int                cyc;
   } exp_t;

   exp_t          sb[$];
   int            checks = 0, errors = 0, cyc = 0, last_wr_cyc = -1;
   logic [DW-1:0] tv [8];
   logic [OW-1:0] ev [8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] acc8(input int a0, a1, a2, a3, a4, a5, a6, a7);
      logic [DW-1:0] r;
      int v[8];
      v = '{a0, a1, a2, a3, a4, a5, a6, a7};
      r = '0;
      for (int g = 0; g < VL; g++) r[g*ACC_W +: ACC_W] = ACC_W'(v[g]);
      return r;
   endfunction

   function automatic logic [OW-1:0] out8(input logic [7:0] b0, b1, b2, b3, b4, b5, b6, b7);
      return {b7, b6, b5, b4, b3, b2, b1, b0};
   endfunction

   task automatic set_all(input logic [DW-1:0] d, input logic [OW-1:0] x);
      for (int i = 0; i < 8; i++) begin
         tv[i] = d;
         ev[i] = x;
      end
   endtask

   // n tiles back-to-back; tiles from n_skip onward are out-pass tiles with expectations
   task automatic drive(input int n, input int n_skip, input logic [1:0] md, input int err_beat,
                        input bit lat);
      exp_t e;
      start = 1'b1;
      mode  = md;
      @(posedge clk); #1;
      start = 1'b0;
      for (int t = 0; t < n; t++) begin
         for (int k = 0; k < VL; k++) begin
            acc   = tv[t];
            start = (k == VL-1 && t < n-1) || (t == 0 && k == err_beat);
            mode  = (t == 0 && k == err_beat) ? 2'd0 : md;
            if (t >= n_skip) begin
               e.addr = ADDR_W'((t - n_skip) * VL + k);
               e.data = ev[t];
               e.cyc  = lat ? cyc + 1 : -1;
               sb.push_back(e);
            end
            @(posedge clk); #1;
         end
      end
      start = 1'b0;
      mode  = md;
      acc   = '0;
   endtask

   task automatic wait_done(input string name);
      bit seen;
      int dc;
      seen = 1'b0;
      dc   = 0;
      for (int i = 0; i < 80 && !seen; i++) begin
         @(negedge clk);
         if (o_done === 1'b1) begin
            seen = 1'b1;
            dc   = cyc;
         end
      end
      chk({name, "_done_seen"}, 64'(seen), 64'd1);
      if (seen) begin
         chk({name, "_all_writes_seen"}, 64'(sb.size()), 64'd0);
         chk({name, "_done_after_last_write"}, 64'(dc), 64'(last_wr_cyc + 1));
         chk({name, "_idle_at_done"}, 64'(o_busy), 64'd0);
      end
   endtask

   task automatic run_int8_1000(input string name);
      set_all(acc8(1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000),
              out8(8'h7D, 8'h7D, 8'h7D, 8'h7D, 8'h7D, 8'h7D, 8'h7D, 8'h7D));
      drive(4, 4, 2'd0, -1, 1'b0);
      repeat (30) @(posedge clk);
      #1;
      chk({name, "_shift"}, 64'(o_shift), 64'd3);
      chk({name, "_armed_busy"}, 64'(o_busy), 64'd1);
      drive(4, 0, 2'd0, -1, 1'b1);
      wait_done(name);
      chk({name, "_no_err"}, 64'(o_err), 64'd0);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // monitor: pop and compare every write the DUT presents
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && o_wr_en === 1'b1) begin
            last_wr_cyc = cyc;
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: addr %0h data %0h with empty scoreboard",
                        o_wr_addr, o_wr_data);
            end else begin
               e = sb.pop_front();
               chk("wr_addr", 64'(o_wr_addr), 64'(e.addr));
               chk("wr_data", o_wr_data, e.data);
               if (e.cyc >= 0) chk("wr_latency", 64'(cyc), 64'(e.cyc));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_wr_en", 64'(o_wr_en), 64'd0);
      chk("rst_wr_addr", 64'(o_wr_addr), 64'd0);
      chk("rst_wr_data", o_wr_data, 64'd0);
      chk("rst_shift", 64'(o_shift), 64'd0);
      chk("rst_busy", 64'(o_busy), 64'd0);
      chk("rst_done", 64'(o_done), 64'd0);
      chk("rst_err", 64'(o_err), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      run_int8_1000("int8");

      set_all(acc8(-8388608, 0, 0, 0, 0, 0, 0, 0), out8(8'hF9, 0, 0, 0, 0, 0, 0, 0));
      drive(4, 4, 2'd1, -1, 1'b0);
      repeat (30) @(posedge clk);
      #1;
      chk("int4_shift", 64'(o_shift), 64'd20);
      drive(4, 0, 2'd1, -1, 1'b1);
      wait_done("int4");

      set_all(acc8(96, -97, 0, 0, 0, 0, 0, 0), out8(8'h02, 8'hFE, 0, 0, 0, 0, 0, 0));
      drive(4, 0, 2'd2, -1, 1'b1);
      wait_done("vsq");
      chk("vsq_shift", 64'(o_shift), 64'd6);

      set_all(acc8(3000, -3000, 16, -16, 47, 48, 0, 100),
              out8(8'h5E, 8'hA2, 8'h01, 8'h00, 8'h01, 8'h02, 8'h00, 8'h03));
      drive(8, 4, 2'd0, -1, 1'b0);
      wait_done("start_in_shift");
      chk("start_in_shift_shift", 64'(o_shift), 64'd5);
      chk("start_in_shift_no_err", 64'(o_err), 64'd0);

      set_all(acc8(640, -640, 0, 0, 0, 0, 0, 0), out8(8'h07, 8'hF9, 0, 0, 0, 0, 0, 0));
      drive(4, 0, 2'd2, 3, 1'b1);
      wait_done("mid_tile_start");
      chk("mid_tile_start_err", 64'(o_err), 64'd1);

      set_all(acc8(1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000),
              out8(8'h7D, 8'h7D, 8'h7D, 8'h7D, 8'h7D, 8'h7D, 8'h7D, 8'h7D));
      drive(4, 4, 2'd0, -1, 1'b0);
      repeat (30) @(posedge clk);
      #1;
      start = 1'b1;
      mode  = 2'd0;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < 5; k++) begin
         exp_t e;
         acc = tv[0];
         if (k < 4) begin
            e.addr = ADDR_W'(k);
            e.data = ev[0];
            e.cyc  = cyc + 1;
            sb.push_back(e);
         end
         @(posedge clk); #1;
      end
      rst = 1'b1;
      #1;
      chk("abort_wr_en", 64'(o_wr_en), 64'd0);
      chk("abort_wr_data", o_wr_data, 64'd0);
      chk("abort_wr_addr", 64'(o_wr_addr), 64'd0);
      chk("abort_shift", 64'(o_shift), 64'd0);
      chk("abort_busy", 64'(o_busy), 64'd0);
      chk("abort_err", 64'(o_err), 64'd0);
      chk("abort_writes_seen", 64'(sb.size()), 64'd0);
      acc = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk); #1;

      run_int8_1000("rerun");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
